// File: rtl/wave_reg_iface_if.sv
// CPU-side byte bus for the wave channel register block.
// The master drives requests; the slave returns registered read data and a one-cycle ack.
interface wave_reg_iface_if;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_wr;
  logic       bus_rd;
  logic [7:0] bus_rdata;
  logic       bus_ack;

  modport master (
    output bus_addr,
    output bus_wdata,
    output bus_wr,
    output bus_rd,
    input  bus_rdata,
    input  bus_ack
  );

  modport slave (
    input  bus_addr,
    input  bus_wdata,
    input  bus_wr,
    input  bus_rd,
    output bus_rdata,
    output bus_ack
  );
endinterface

// File: rtl/wave_reg_iface.sv
// NR30-NR34 and wave RAM register file for the wave channel.
// Decodes CPU byte accesses, holds channel configuration and generates the trigger pulse.
module wave_reg_iface #(
  parameter int unsigned TRIG_CYCLES = 1,
  parameter int unsigned LEN_W       = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  wave_reg_iface_if.slave  bus,
  output logic             o_dac_enable,
  output logic [LEN_W-1:0] o_length,
  output logic [1:0]       o_vol,
  output logic [10:0]      o_freq,
  output logic             o_length_enable,
  output logic             o_trigger,
  output logic [127:0]     o_samples
);

  localparam logic [3:0] CntLoad = 4'(TRIG_CYCLES - 1);

  typedef enum logic {StIdle, StPulse} state_e;

  state_e           r_state;
  logic [3:0]       r_cnt;
  logic             r_trigger;
  logic             r_dac_en;
  logic [LEN_W-1:0] r_length;
  logic [1:0]       r_vol;
  logic [10:0]      r_freq;
  logic             r_len_en;
  logic [127:0]     r_samples;
  logic [7:0]       r_rdata;
  logic             r_ack;

  logic       w_wr;
  logic       w_rd;
  logic       w_wave_sel;
  logic [6:0] w_nib_base;
  logic [7:0] w_rd_data;
  logic       w_trig_fire;
  logic       w_trig_kill;

  assign w_wr       = bus.bus_wr;
  assign w_rd       = bus.bus_rd & ~bus.bus_wr;
  assign w_wave_sel = (bus.bus_addr[7:4] == 4'h3);
  // Byte k holds sample 2k in its low nibble slot and sample 2k+1 above it.
  assign w_nib_base = {bus.bus_addr[3:0], 3'b000};

  // Trigger qualification uses the DAC enable held before this edge.
  assign w_trig_fire = w_wr && (bus.bus_addr == 8'h1E) && bus.bus_wdata[7] && r_dac_en;
  assign w_trig_kill = w_wr && (bus.bus_addr == 8'h1A) && !bus.bus_wdata[7];

  always_comb begin
    w_rd_data = 8'hFF;
    case (bus.bus_addr)
      8'h1A:   w_rd_data = {r_dac_en, 7'h7F};
      8'h1C:   w_rd_data = {1'b1, r_vol, 5'h1F};
      8'h1E:   w_rd_data = {1'b1, r_len_en, 6'h3F};
      default: begin
        if (w_wave_sel) begin
          w_rd_data = {r_samples[w_nib_base +: 4], r_samples[(w_nib_base + 7'd4) +: 4]};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dac_en  <= 1'b0;
      r_length  <= '0;
      r_vol     <= 2'b00;
      r_freq    <= 11'd0;
      r_len_en  <= 1'b0;
      r_samples <= '0;
    end else if (w_wr) begin
      case (bus.bus_addr)
        8'h1A:   r_dac_en <= bus.bus_wdata[7];
        8'h1B:   r_length <= bus.bus_wdata[LEN_W-1:0];
        8'h1C:   r_vol    <= bus.bus_wdata[6:5];
        8'h1D:   r_freq[7:0] <= bus.bus_wdata;
        8'h1E: begin
          r_freq[10:8] <= bus.bus_wdata[2:0];
          r_len_en     <= bus.bus_wdata[6];
        end
        default: begin
          if (w_wave_sel) begin
            r_samples[w_nib_base +: 4]           <= bus.bus_wdata[7:4];
            r_samples[(w_nib_base + 7'd4) +: 4]  <= bus.bus_wdata[3:0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack   <= 1'b0;
      r_rdata <= 8'h00;
    end else begin
      r_ack <= w_wr | bus.bus_rd;
      if (w_wr) begin
        r_rdata <= 8'hFF;
      end else if (w_rd) begin
        r_rdata <= w_rd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= 4'd0;
      r_trigger <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_trig_fire) begin
            r_state   <= StPulse;
            r_cnt     <= CntLoad;
            r_trigger <= 1'b1;
          end
        end
        StPulse: begin
          if (w_trig_fire) begin
            r_cnt <= CntLoad;
          end else if (w_trig_kill || (r_cnt == 4'd0)) begin
            r_state   <= StIdle;
            r_cnt     <= 4'd0;
            r_trigger <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state   <= StIdle;
          r_trigger <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bus_rdata     = r_rdata;
  assign bus.bus_ack       = r_ack;
  assign o_dac_enable      = r_dac_en;
  assign o_length          = r_length;
  assign o_vol             = r_vol;
  assign o_freq            = r_freq;
  assign o_length_enable   = r_len_en;
  assign o_trigger         = r_trigger;
  assign o_samples         = r_samples;

endmodule

// File: tb/tb_wave_reg_iface.sv
// Directed bench for wave_reg_iface: two instances (1- and 4-cycle trigger) share one stimulus.
module tb_wave_reg_iface;
  logic clk;
  logic rst_n;

  wave_reg_iface_if u_if1 ();
  wave_reg_iface_if u_if4 ();

  logic         dac1, dac4, len_en1, len_en4, trig1, trig4;
  logic [5:0]   len1, len4;
  logic [1:0]   vol1, vol4;
  logic [10:0]  freq1, freq4;
  logic [127:0] samp1, samp4;

  int n_checks;
  int n_pass;

  assign u_if4.bus_addr  = u_if1.bus_addr;
  assign u_if4.bus_wdata = u_if1.bus_wdata;
  assign u_if4.bus_wr    = u_if1.bus_wr;
  assign u_if4.bus_rd    = u_if1.bus_rd;

  wave_reg_iface #(.TRIG_CYCLES(1), .LEN_W(6)) u_dut1 (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (u_if1),
    .o_dac_enable    (dac1),
    .o_length        (len1),
    .o_vol           (vol1),
    .o_freq          (freq1),
    .o_length_enable (len_en1),
    .o_trigger       (trig1),
    .o_samples       (samp1)
  );

  wave_reg_iface #(.TRIG_CYCLES(4), .LEN_W(6)) u_dut4 (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (u_if4),
    .o_dac_enable    (dac4),
    .o_length        (len4),
    .o_vol           (vol4),
    .o_freq          (freq4),
    .o_length_enable (len_en4),
    .o_trigger       (trig4),
    .o_samples       (samp4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One bus cycle: drive on the falling edge, sample 1ns after the rising edge.
  task automatic bus_xfer(input logic wr, input logic rd, input logic [7:0] addr,
                          input logic [7:0] data, output logic [7:0] rdata, output logic ack);
    @(negedge clk);
    u_if1.bus_wr    = wr;
    u_if1.bus_rd    = rd;
    u_if1.bus_addr  = addr;
    u_if1.bus_wdata = data;
    @(posedge clk);
    #1;
    rdata = u_if1.bus_rdata;
    ack   = u_if1.bus_ack;
    u_if1.bus_wr = 1'b0;
    u_if1.bus_rd = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] rd;
    logic       ack;
    logic [9:0] trace;
    int         highs;

    n_checks = 0;
    n_pass   = 0;
    u_if1.bus_wr    = 1'b0;
    u_if1.bus_rd    = 1'b0;
    u_if1.bus_addr  = 8'h00;
    u_if1.bus_wdata = 8'h00;
    rst_n = 1'b0;
    #3;
    check("rst_samples", samp1, 128'd0);
    check("rst_trig", {trig1, trig4}, 2'b00);
    check("rst_ack_rdata", {u_if1.bus_ack, u_if1.bus_rdata}, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 16; k++) begin
      bus_xfer(1'b1, 1'b0, 8'(8'h30 + k), {4'(2 * k), 4'(2 * k + 1)}, rd, ack);
    end
    check("wave_ack_rdata", {ack, rd}, {1'b1, 8'hFF});
    check("wave_samples", samp1, 128'hFEDCBA9876543210FEDCBA9876543210);
    bus_xfer(1'b0, 1'b1, 8'h35, 8'h00, rd, ack);
    check("rd_0x35", {ack, rd}, {1'b1, 8'hAB});
    idle_cycle();
    check("ack_drop_hold", {u_if1.bus_ack, u_if1.bus_rdata}, {1'b0, 8'hAB});

    bus_xfer(1'b1, 1'b0, 8'h1B, 8'hFF, rd, ack);
    check("length_trunc", len1, 6'h3F);

    bus_xfer(1'b1, 1'b0, 8'h1A, 8'h80, rd, ack);
    bus_xfer(1'b1, 1'b0, 8'h1C, 8'h20, rd, ack);
    bus_xfer(1'b1, 1'b0, 8'h1D, 8'hD0, rd, ack);
    check("trig_before", trig1, 1'b0);
    bus_xfer(1'b1, 1'b0, 8'h1E, 8'h87, rd, ack);
    check("trig1_first", trig1, 1'b1);
    check("vol_freq_len_en", {vol1, freq1, len_en1}, {2'b01, 11'd2000, 1'b0});
    idle_cycle();
    check("trig1_end", trig1, 1'b0);
    bus_xfer(1'b0, 1'b1, 8'h1E, 8'h00, rd, ack);
    check("rd_nr34", rd, 8'hBF);

    bus_xfer(1'b1, 1'b0, 8'h1A, 8'h00, rd, ack);
    bus_xfer(1'b1, 1'b0, 8'h1D, 8'hD0, rd, ack);
    highs = 0;
    bus_xfer(1'b1, 1'b0, 8'h1E, 8'h87, rd, ack);
    highs += int'(trig1) + int'(trig4);
    for (int i = 0; i < 5; i++) begin
      idle_cycle();
      highs += int'(trig1) + int'(trig4);
    end
    check("dac_off_no_trig", highs, 0);
    check("dac_off_freq", freq1, 11'd2000);

    // Second qualifying write lands two cycles into the 4-cycle pulse.
    bus_xfer(1'b1, 1'b0, 8'h1A, 8'h80, rd, ack);
    bus_xfer(1'b1, 1'b0, 8'h1E, 8'h80, rd, ack);
    trace[0] = trig4;
    idle_cycle();
    trace[1] = trig4;
    bus_xfer(1'b1, 1'b0, 8'h1E, 8'h80, rd, ack);
    trace[2] = trig4;
    for (int i = 3; i < 10; i++) begin
      idle_cycle();
      trace[i] = trig4;
    end
    check("trig4_extend", trace, 10'b0000111111);

    bus_xfer(1'b1, 1'b0, 8'h1E, 8'h80, rd, ack);
    check("trig4_pre_kill", trig4, 1'b1);
    bus_xfer(1'b1, 1'b0, 8'h1A, 8'h00, rd, ack);
    check("trig4_kill", {trig4, dac4}, 2'b00);

    bus_xfer(1'b1, 1'b0, 8'h1A, 8'h80, rd, ack);
    bus_xfer(1'b1, 1'b0, 8'h1E, 8'h80, rd, ack);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_trig", {trig1, trig4}, 2'b00);
    check("midrst_regs", {dac1, vol1, freq1, len1}, 20'd0);
    check("midrst_samples", samp1, 128'd0);
    check("midrst_bus", {u_if1.bus_ack, u_if1.bus_rdata}, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;

    bus_xfer(1'b0, 1'b1, 8'h1A, 8'h00, rd, ack);
    check("rst_rd_nr30", {ack, rd}, {1'b1, 8'h7F});
    bus_xfer(1'b0, 1'b1, 8'h1C, 8'h00, rd, ack);
    check("rst_rd_nr32", rd, 8'h9F);
    bus_xfer(1'b0, 1'b1, 8'h1E, 8'h00, rd, ack);
    check("rst_rd_nr34", rd, 8'hBF);
    bus_xfer(1'b0, 1'b1, 8'h30, 8'h00, rd, ack);
    check("rst_rd_wave", rd, 8'h00);

    bus_xfer(1'b0, 1'b1, 8'h20, 8'h00, rd, ack);
    check("rd_unmapped", {ack, rd}, {1'b1, 8'hFF});
    bus_xfer(1'b0, 1'b1, 8'h30, 8'h00, rd, ack);
    bus_xfer(1'b0, 1'b1, 8'h1B, 8'h00, rd, ack);
    check("rd_nr31_wo", {ack, rd}, {1'b1, 8'hFF});
    bus_xfer(1'b0, 1'b1, 8'h30, 8'h00, rd, ack);
    bus_xfer(1'b1, 1'b1, 8'h1C, 8'h60, rd, ack);
    check("wr_rd_same", {ack, rd, vol1}, {1'b1, 8'hFF, 2'b11});
    idle_cycle();
    check("wr_rd_one_ack", u_if1.bus_ack, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
